// File: rtl/key_scan_arbiter_if.sv
// Key scanner bundle: raw key pins in, debounced levels and key events out.
interface key_scan_arbiter_if #(
    parameter int KEY_NUM = 4,
    parameter int IDX_W   = 2
);
    logic [KEY_NUM-1:0] key_in;
    logic               key_flag;
    logic [IDX_W-1:0]   key_id;
    logic               key_rel;
    logic [KEY_NUM-1:0] key_state;
    logic               busy;

    modport master (
        output key_in,
        input  key_flag, key_id, key_rel, key_state, busy
    );

    modport slave (
        input  key_in,
        output key_flag, key_id, key_rel, key_state, busy
    );
endinterface

// File: rtl/key_scan_arbiter.sv
// Round-robin debouncer sharing one counter among KEY_NUM keys.
// Define KEY_RELEASE_EVT_EN to also report releases (key_rel=1).
module key_scan_arbiter #(
    parameter int               KEY_NUM = 4,
    parameter int               IDX_W   = 2,
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999
) (
    input logic               sys_clk,
    input logic               sys_rst,
    key_scan_arbiter_if.slave kif
);
    typedef enum logic [1:0] {
        SCAN,
        FILTER,
        COMMIT
    } state_t;

    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(KEY_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

    state_t             state;
    logic [KEY_NUM-1:0] meta;
    logic [KEY_NUM-1:0] syn;
    logic [KEY_NUM-1:0] key_state_q;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   own_id;
    logic [CNT_W-1:0]   cnt;
    logic               key_flag_q;
    logic [IDX_W-1:0]   key_id_q;
    logic               key_rel_q;
    logic               busy_q;
    logic               new_lvl;

    assign new_lvl       = ~key_state_q[own_id];
    assign kif.key_flag  = key_flag_q;
    assign kif.key_id    = key_id_q;
    assign kif.key_rel   = key_rel_q;
    assign kif.key_state = key_state_q;
    assign kif.busy      = busy_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            meta <= '1;
            syn  <= '1;
        end else begin
            meta <= kif.key_in;
            syn  <= meta;
        end
    end

    // Levels, not edges, are compared, so a key that waits for its grant
    // is still seen as changed when the scanner reaches it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= SCAN;
            ptr         <= '0;
            own_id      <= '0;
            cnt         <= '0;
            key_state_q <= '1;
            key_flag_q  <= 1'b0;
            key_id_q    <= '0;
            key_rel_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            key_flag_q <= 1'b0;
            unique case (state)
                SCAN: begin
                    ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
                    if (syn[ptr] != key_state_q[ptr]) begin
                        own_id <= ptr;
                        cnt    <= '0;
                        state  <= FILTER;
                        busy_q <= 1'b1;
                    end
                end
                FILTER: begin
                    if (syn[own_id] == key_state_q[own_id]) begin
                        cnt    <= '0;
                        state  <= SCAN;
                        busy_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= COMMIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    key_state_q[own_id] <= new_lvl;
                    cnt                 <= '0;
                    state               <= SCAN;
                    busy_q              <= 1'b0;
`ifdef KEY_RELEASE_EVT_EN
                    key_flag_q <= 1'b1;
                    key_id_q   <= own_id;
                    key_rel_q  <= new_lvl;
`else
                    if (!new_lvl) begin
                        key_flag_q <= 1'b1;
                        key_id_q   <= own_id;
                    end
                    key_rel_q <= 1'b0;
`endif
                end
                default: begin
                    state  <= SCAN;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_scan_arbiter.sv
// Directed bench for key_scan_arbiter (KEY_NUM=4, CNT_MAX=24).
module tb_key_scan_arbiter;
    logic sys_clk;
    logic sys_rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   flag_cnt = 0;
    int   base;
    int   c0;
    int   lat;
    int   gap;
    logic [1:0] fid [0:15];
    logic       frel [0:15];
    int         fcyc [0:15];
    logic [29:0] pat;

    key_scan_arbiter_if #(.KEY_NUM(4), .IDX_W(2)) kif ();

    key_scan_arbiter #(
        .KEY_NUM(4),
        .IDX_W  (2),
        .CNT_W  (20),
        .CNT_MAX(20'd24)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .kif    (kif)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (kif.key_flag === 1'b1) begin
            if (flag_cnt < 16) begin
                fid[4'(flag_cnt)]  = kif.key_id;
                frel[4'(flag_cnt)] = kif.key_rel;
                fcyc[4'(flag_cnt)] = cyc;
            end
            flag_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic wait_flag(input int b, input int budget);
        for (int i = 0; i < budget && flag_cnt <= b; i++) tick(1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst    = 1'b1;
        kif.key_in = 4'hF;
        pat        = 30'b101100_111010_001101_100101_110100;
        tick(3);
        check("rst_flag", 32'(kif.key_flag), 32'd0);
        check("rst_id", 32'(kif.key_id), 32'd0);
        check("rst_rel", 32'(kif.key_rel), 32'd0);
        check("rst_state", 32'(kif.key_state), 32'hF);
        check("rst_busy", 32'(kif.busy), 32'd0);
        sys_rst = 1'b0;
        tick(5);

        // single press on key 2
        base = flag_cnt;
        kif.key_in = 4'b1011;
        c0 = cyc;
        wait_flag(base, 40);
        tick(70);
        lat = fcyc[4'(base)] - c0;
        check("t1_count", 32'(flag_cnt), 32'(base + 1));
        check("t1_id", 32'(fid[4'(base)]), 32'd2);
        check("t1_latency", 32'(lat >= 27 && lat <= 32), 32'd1);
        check("t1_state", 32'(kif.key_state), 32'hB);
        check("t1_pulse", 32'(kif.key_flag), 32'd0);

        // release of key 2
        base = flag_cnt;
        kif.key_in = 4'hF;
        tick(40);
`ifdef KEY_RELEASE_EVT_EN
        check("t6_count", 32'(flag_cnt), 32'(base + 1));
        check("t6_id", 32'(fid[4'(base)]), 32'd2);
        check("t6_rel", 32'(frel[4'(base)]), 32'd1);
`else
        check("t6_count", 32'(flag_cnt), 32'(base));
        check("t6_rel", 32'(kif.key_rel), 32'd0);
`endif
        check("t6_state", 32'(kif.key_state), 32'hF);

        // bouncing key 1, then held
        base = flag_cnt;
        for (int i = 0; i < 30; i++) begin
            kif.key_in[1] = pat[i];
            tick(1);
        end
        check("t2_bounce", 32'(flag_cnt), 32'(base));
        kif.key_in[1] = 1'b0;
        wait_flag(base, 40);
        tick(30);
        check("t2_count", 32'(flag_cnt), 32'(base + 1));
        check("t2_id", 32'(fid[4'(base)]), 32'd1);
        check("t2_state", 32'(kif.key_state), 32'hD);
        kif.key_in = 4'hF;
        tick(40);
        check("t2_release", 32'(kif.key_state), 32'hF);

        // short glitch on key 0
        base = flag_cnt;
        kif.key_in[0] = 1'b0;
        tick(10);
        check("t3_busy_hi", 32'(kif.busy), 32'd1);
        kif.key_in[0] = 1'b1;
        tick(3);
        check("t3_busy_lo", 32'(kif.busy), 32'd0);
        tick(30);
        check("t3_count", 32'(flag_cnt), 32'(base));
        check("t3_state", 32'(kif.key_state), 32'hF);

        // keys 0 and 3 fall together
        base = flag_cnt;
        kif.key_in = 4'b0110;
        wait_flag(base + 1, 100);
        tick(10);
        gap = fcyc[4'(base + 1)] - fcyc[4'(base)];
        check("t4_count", 32'(flag_cnt), 32'(base + 2));
        check("t4_ids", 32'(({fid[4'(base)], fid[4'(base + 1)]} === 4'b0011) ||
                            ({fid[4'(base)], fid[4'(base + 1)]} === 4'b1100)),
              32'd1);
        check("t4_gap", 32'(gap >= 25), 32'd1);
        check("t4_state", 32'(kif.key_state), 32'h6);
        kif.key_in = 4'hF;
        tick(100);
        check("t4_release", 32'(kif.key_state), 32'hF);

        // reset in the middle of a filter window
        base = flag_cnt;
        kif.key_in[2] = 1'b0;
        for (int i = 0; i < 20 && kif.busy !== 1'b1; i++) tick(1);
        tick(10);
        check("t5_busy", 32'(kif.busy), 32'd1);
        sys_rst = 1'b1;
        tick(1);
        check("t5_rst_state", 32'(kif.key_state), 32'hF);
        check("t5_rst_busy", 32'(kif.busy), 32'd0);
        check("t5_rst_id", 32'(kif.key_id), 32'd0);
        sys_rst = 1'b0;
        tick(20);
        check("t5_aborted", 32'(flag_cnt), 32'(base));
        wait_flag(base, 40);
        tick(2);
        check("t5_count", 32'(flag_cnt), 32'(base + 1));
        check("t5_id", 32'(fid[4'(base)]), 32'd2);
        check("t5_state", 32'(kif.key_state), 32'hB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
